// File: rtl/secded_decoder_engine_pkg.sv
// secded_pkg: codeword bit map, flag codes, engine states and result packing
package secded_pkg;
  localparam int P0 = 0, P1 = 1, P2 = 2, D1 = 3, P4 = 4, D2 = 5, D3 = 6, D4 = 7, P8 = 8;
  localparam int D5 = 9, D6 = 10, D7 = 11, D8 = 12, D9 = 13, D10 = 14, D11 = 15;
  localparam logic [1:0] FLG_NONE = 2'b00, FLG_SGL = 2'b01, FLG_DBL = 2'b10;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE} state_t;
  function automatic logic [15:0] pack_result(input logic [11:1] d, input logic [1:0] f);
    return {f, 3'b000, d};
  endfunction
endpackage

// File: rtl/secded_dec16.sv
// secded_dec16: combinational SECDED decode of one 16-bit codeword
module secded_dec16
  import secded_pkg::*;
(
  input  logic [15:0] cw,
  output logic [11:1] data,
  output logic [1:0]  flags
);
  logic [3:0] s;
  logic q;
  logic [15:0] fix;
  always_comb begin
    s[0] = cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4] ^ cw[D5] ^ cw[D7] ^ cw[D9] ^ cw[D11];
    s[1] = cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4] ^ cw[D6] ^ cw[D7] ^ cw[D10] ^ cw[D11];
    s[2] = cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4] ^ cw[D8] ^ cw[D9] ^ cw[D10] ^ cw[D11];
    s[3] = cw[P8] ^ cw[D5] ^ cw[D6] ^ cw[D7] ^ cw[D8] ^ cw[D9] ^ cw[D10] ^ cw[D11];
    q = cw[P0] ^ (^cw[15:1]);
    fix = cw ^ (q ? 16'd1 << s : 16'd0);
    data = {fix[D11], fix[D10], fix[D9], fix[D8], fix[D7], fix[D6], fix[D5],
            fix[D4], fix[D3], fix[D2], fix[D1]};
    flags = q ? FLG_SGL : (|s ? FLG_DBL : FLG_NONE);
  end
endmodule

// File: rtl/secded_decoder_engine.sv
// secded_decoder_engine: walks NUM_MSG codewords in memory, writes decoded data plus flags
module secded_decoder_engine
  import secded_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);
  localparam int IW = NUM_MSG > 1 ? $clog2(NUM_MSG) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [15:0] cw, res;
  logic [11:1] data;
  logic [1:0] flags;
  logic go, last;
  logic [AW-1:0] src, dst;
  secded_dec16 u_dec (.cw(cw), .data(data), .flags(flags));
  assign go = (state == IDLE || state == DONE) && start;
  assign last = idx == IW'(NUM_MSG - 1);
  assign src = AW'(SRC_BASE) + AW'({idx, 1'b0});
  assign dst = AW'(DST_BASE) + AW'({idx, 1'b0});
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? RD_LO : state;
      RD_LO:      nxt = RD_HI;
      RD_HI:      nxt = CAP;
      CAP:        nxt = DEC;
      DEC:        nxt = WR_LO;
      WR_LO:      nxt = WR_HI;
      WR_HI:      nxt = last ? DONE : RD_LO;
      default:    nxt = IDLE;
    endcase
  end
  assign mem_wr_en = state == WR_LO || state == WR_HI;
  assign mem_addr = state == RD_LO ? src :
                    state == RD_HI ? src + AW'(1) :
                    state == WR_LO ? dst :
                    state == WR_HI ? dst + AW'(1) : '0;
  assign mem_wr_data = state == WR_LO ? res[7:0] : state == WR_HI ? res[15:8] : 8'h00;
  // done is registered, so it trails entry into DONE by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      done <= 1'b0;
      cw <= '0;
      res <= '0;
    end else begin
      state <= nxt;
      done <= state == DONE && !start;
      if (go) idx <= '0;
      else if (state == WR_HI && !last) idx <= idx + 1'b1;
      if (state == RD_HI) cw[7:0] <= mem_rd_data;
      if (state == CAP) cw[15:8] <= mem_rd_data;
      if (state == DEC) res <= pack_result(data, flags);
    end
  end
endmodule
